// File: rtl/mac_pkg.sv
// Shared MAC-array definitions: width defaults, drain FSM states and the
// saturating add used by the accumulator.
package mac_pkg;

  localparam int IN_BIT_DEF     = 32;
  localparam int ACC_BIT_DEF    = 40;
  localparam int LEN_W_DEF      = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  // Working width of sat_add; must exceed the widest accumulator by one bit.
  localparam int CALC_W         = 64;

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_FLUSH} acc_state_t;

  typedef struct packed {
    logic              sat;
    logic [CALC_W-1:0] sum;
  } sat_sum_t;

  // Both operands arrive sign-extended to CALC_W; the sum is clamped to acc_bit.
  function automatic sat_sum_t sat_add(input logic signed [CALC_W-1:0] acc,
                                       input logic signed [CALC_W-1:0] ext_in,
                                       input int                       acc_bit);
    logic signed [CALC_W-1:0] s;
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    sat_sum_t                 r;
    s     = acc + ext_in;
    hi    = (64'sd1 <<< (acc_bit - 1)) - 64'sd1;
    lo    = ~hi;
    r.sat = 1'b0;
    r.sum = s;
    if (s > hi) begin
      r.sat = 1'b1;
      r.sum = hi;
    end else if (s < lo) begin
      r.sat = 1'b1;
      r.sum = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_acc_drain_fifo.sv
// Small synchronous FIFO with a count-based full/empty and a head that reads
// as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign valid   = (count != '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mac_acc_drain.sv
// Accumulates cfg_len signed MAC results into a saturating sum per job and
// queues finished sums for the output consumer.
module mac_acc_drain
  import mac_pkg::*;
#(
  parameter int IN_BIT     = IN_BIT_DEF,
  parameter int ACC_BIT    = ACC_BIT_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               in_valid,
  input  logic [IN_BIT-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_BIT-1:0] out_data,
  output logic               out_sat,
  output logic               busy
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and held data stays stable until taken.

  acc_state_t         state;
  acc_state_t         state_next;
  logic [ACC_BIT-1:0] acc;
  logic               sat;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   cnt_inc;
  logic               beat;
  logic               push;
  logic               fifo_full;
  logic [ACC_BIT:0]   head;
  sat_sum_t           sum_r;

  assign in_ready = (state == ST_ACC);
  assign busy     = (state != ST_IDLE);
  assign beat     = in_ready & in_valid;
  assign cnt_inc  = cnt + 1'b1;
  assign sum_r    = sat_add({{(CALC_W - ACC_BIT){acc[ACC_BIT-1]}}, acc},
                            {{(CALC_W - IN_BIT){in_data[IN_BIT-1]}}, in_data},
                            ACC_BIT);

  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_next = (cfg_len == '0) ? ST_FLUSH : ST_ACC;
      ST_ACC:   if (beat && cnt_inc == len_q) state_next = ST_FLUSH;
      ST_FLUSH: begin
        push = ~fifo_full;
        if (!fifo_full) state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      acc   <= '0;
      sat   <= 1'b0;
      len_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && start) begin
        acc   <= '0;
        sat   <= 1'b0;
        len_q <= cfg_len;
        cnt   <= '0;
      end else if (beat) begin
        acc <= ACC_BIT'(sum_r.sum);
        sat <= sat | sum_r.sat;
        cnt <= cnt_inc;
      end
    end
  end

  sync_fifo #(
    .WIDTH (ACC_BIT + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({sat, acc}),
    .pop       (out_ready),
    .full      (fifo_full),
    .valid     (out_valid),
    .head      (head)
  );

  assign out_data = head[ACC_BIT-1:0];
  assign out_sat  = head[ACC_BIT];

endmodule
